mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 191 +++++++++++++++++++
 tb/tb_mem_stage.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM pipeline stage: forwards EX/MEM results to MEM/WB and runs a blocking dcache handshake.
// Optional performance counters are enabled with `define MEM_STAGE_PERF_CNT_EN.
module mem_stage (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        in_valid,
  input  logic [31:0] alu_out,
  input  logic [31:0] store_dat,
  input  logic [4:0]  write_reg,
  input  logic [31:0] pc4,
  input  logic [31:0] lower_zero,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        memtoreg,
  input  logic        regWEN,
  input  logic        lui_flag,
  input  logic        jal_flag,
  input  logic        halt,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  output logic        stall,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_reg,
  output logic        wb_wen,
  output logic        halt_out
`ifdef MEM_STAGE_PERF_CNT_EN
  ,
  output logic [31:0] access_cnt,
  output logic [31:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, ACCESS, HALTED} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d, store_q, store_d, pc4_q, pc4_d, lz_q, lz_d;
  logic        ren_q, ren_d, wen_q, wen_d, m2r_q, m2r_d, regwen_q, regwen_d;
  logic        lui_q, lui_d, jal_q, jal_d;
  logic [4:0]  wreg_q, wreg_d;
  logic        wb_valid_q, wb_valid_d, wb_wen_q, wb_wen_d, halt_q, halt_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_reg_q, wb_reg_d;
  logic        in_access;

  function automatic logic [31:0] wb_sel(input logic m2r, input logic jal, input logic lui,
                                         input logic [31:0] load, input logic [31:0] pc,
                                         input logic [31:0] lz, input logic [31:0] alu);
    if (m2r)      return load;
    else if (jal) return pc;
    else if (lui) return lz;
    else          return alu;
  endfunction

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      store_q    <= '0;
      pc4_q      <= '0;
      lz_q       <= '0;
      ren_q      <= 1'b0;
      wen_q      <= 1'b0;
      m2r_q      <= 1'b0;
      regwen_q   <= 1'b0;
      lui_q      <= 1'b0;
      jal_q      <= 1'b0;
      wreg_q     <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_reg_q   <= '0;
      wb_wen_q   <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      store_q    <= store_d;
      pc4_q      <= pc4_d;
      lz_q       <= lz_d;
      ren_q      <= ren_d;
      wen_q      <= wen_d;
      m2r_q      <= m2r_d;
      regwen_q   <= regwen_d;
      lui_q      <= lui_d;
      jal_q      <= jal_d;
      wreg_q     <= wreg_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_reg_q   <= wb_reg_d;
      wb_wen_q   <= wb_wen_d;
      halt_q     <= halt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    store_d    = store_q;
    pc4_d      = pc4_q;
    lz_d       = lz_q;
    ren_d      = ren_q;
    wen_d      = wen_q;
    m2r_d      = m2r_q;
    regwen_d   = regwen_q;
    lui_d      = lui_q;
    jal_d      = jal_q;
    wreg_d     = wreg_q;
    wb_valid_d = 1'b0;
    wb_data_d  = wb_data_q;
    wb_reg_d   = wb_reg_q;
    wb_wen_d   = wb_wen_q;
    halt_d     = halt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (halt) begin
            state_d    = HALTED;
            wb_valid_d = 1'b1;
            wb_wen_d   = 1'b0;
            halt_d     = 1'b1;
          end else if (mem_read || mem_write) begin
            // Read+write together is treated as a store.
            state_d  = ACCESS;
            addr_d   = alu_out;
            store_d  = store_dat;
            pc4_d    = pc4;
            lz_d     = lower_zero;
            ren_d    = mem_read && !mem_write;
            wen_d    = mem_write;
            m2r_d    = memtoreg;
            regwen_d = regWEN;
            lui_d    = lui_flag;
            jal_d    = jal_flag;
            wreg_d   = write_reg;
          end else begin
            wb_valid_d = 1'b1;
            wb_data_d  = wb_sel(memtoreg, jal_flag, lui_flag, dmemload, pc4, lower_zero, alu_out);
            wb_reg_d   = write_reg;
            wb_wen_d   = regWEN;
          end
        end
      end
      ACCESS: begin
        if (dhit) begin
          state_d    = IDLE;
          wb_valid_d = 1'b1;
          wb_data_d  = wb_sel(m2r_q, jal_q, lui_q, dmemload, pc4_q, lz_q, addr_q);
          wb_reg_d   = wreg_q;
          wb_wen_d   = regwen_q;
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  assign in_access = (state_q == ACCESS);
  assign dmemREN   = in_access && ren_q;
  assign dmemWEN   = in_access && wen_q;
  assign dmemaddr  = in_access ? addr_q  : '0;
  assign dmemstore = in_access ? store_q : '0;
  assign stall     = in_access && !dhit;
  assign wb_valid  = wb_valid_q;
  assign wb_data   = wb_data_q;
  assign wb_reg    = wb_reg_q;
  assign wb_wen    = wb_wen_q;
  assign halt_out  = halt_q;

`ifdef MEM_STAGE_PERF_CNT_EN
  logic [31:0] access_cnt_q, stall_cnt_q;

  // Both counters wrap naturally at 2^32.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      access_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      if (in_access && dhit) access_cnt_q <= access_cnt_q + 32'd1;
      if (stall)             stall_cnt_q  <= stall_cnt_q + 32'd1;
    end
  end

  assign access_cnt = access_cnt_q;
  assign stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized traffic vs a reference model.
module tb_mem_stage;
  logic        CLK, nRST, in_valid, mem_read, mem_write, memtoreg, regWEN, lui_flag, jal_flag, halt;
  logic [31:0] alu_out, store_dat, pc4, lower_zero, dmemaddr, dmemstore, dmemload, wb_data;
  logic [4:0]  write_reg, wb_reg;
  logic        dmemREN, dmemWEN, dhit, stall, wb_valid, wb_wen, halt_out;
`ifdef MEM_STAGE_PERF_CNT_EN
  logic [31:0] access_cnt, stall_cnt;
`endif
  int checks = 0;
  int failures = 0;

  mem_stage dut (
    .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .alu_out(alu_out), .store_dat(store_dat),
    .write_reg(write_reg), .pc4(pc4), .lower_zero(lower_zero), .mem_read(mem_read),
    .mem_write(mem_write), .memtoreg(memtoreg), .regWEN(regWEN), .lui_flag(lui_flag),
    .jal_flag(jal_flag), .halt(halt), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dhit(dhit), .dmemload(dmemload),
    .stall(stall), .wb_valid(wb_valid), .wb_data(wb_data), .wb_reg(wb_reg), .wb_wen(wb_wen),
    .halt_out(halt_out)
`ifdef MEM_STAGE_PERF_CNT_EN
    , .access_cnt(access_cnt), .stall_cnt(stall_cnt)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic drive(input logic v, input logic rd, input logic wr, input logic m2r,
                       input logic rw, input logic lu, input logic jl, input logic hl,
                       input logic [31:0] a, input logic [31:0] s, input logic [31:0] p,
                       input logic [31:0] lz, input logic [4:0] r);
    in_valid = v; mem_read = rd; mem_write = wr; memtoreg = m2r; regWEN = rw;
    lui_flag = lu; jal_flag = jl; halt = hl; alu_out = a; store_dat = s; pc4 = p;
    lower_zero = lz; write_reg = r;
  endtask

  task automatic junk(input logic v);
    drive(v, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          1'($urandom), 1'($urandom), $urandom, $urandom, $urandom, $urandom, 5'($urandom));
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0);
  endtask

  task automatic reset_dut();
    @(negedge CLK);
    nRST = 1'b0; idle(); dhit = 1'b0; dmemload = 32'h0;
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    nRST = 1'b0; junk(1'b1); dhit = 1'b1; dmemload = $urandom;
    @(posedge CLK); #1; @(posedge CLK); #1;
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL rst_wb_valid act=%b exp=0", wb_valid); end
    checks++; if (wb_data !== 32'h0) begin failures++; $display("FAIL rst_wb_data act=%h exp=0", wb_data); end
    checks++; if (wb_reg !== 5'd0) begin failures++; $display("FAIL rst_wb_reg act=%h exp=0", wb_reg); end
    checks++; if (wb_wen !== 1'b0 || halt_out !== 1'b0) begin failures++; $display("FAIL rst_wen_halt act=%b%b exp=00", wb_wen, halt_out); end
    checks++; if ({dmemREN, dmemWEN, stall} !== 3'b000) begin failures++; $display("FAIL rst_dmem act=%b exp=000", {dmemREN, dmemWEN, stall}); end
    checks++; if (dmemaddr !== 32'h0 || dmemstore !== 32'h0) begin failures++; $display("FAIL rst_addr act=%h/%h exp=0", dmemaddr, dmemstore); end
`ifdef MEM_STAGE_PERF_CNT_EN
    checks++; if (access_cnt !== 32'h0 || stall_cnt !== 32'h0) begin failures++; $display("FAIL rst_cnt act=%0d/%0d exp=0", access_cnt, stall_cnt); end
`endif
    @(negedge CLK);
    nRST = 1'b1; idle(); dhit = 1'b0;
    @(posedge CLK); #1;
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL rst_idle_valid act=%b exp=0", wb_valid); end
  endtask

  task automatic test_alu();
    @(negedge CLK);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 32'h0, 5'd5);
    #1;
    checks++; if (dmemREN !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL alu_ren_stall act=%b%b exp=00", dmemREN, stall); end
    @(posedge CLK); #1;
    checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL alu_valid act=%b exp=1", wb_valid); end
    checks++; if (wb_data !== 32'h10) begin failures++; $display("FAIL alu_data act=%h exp=10", wb_data); end
    checks++; if (wb_reg !== 5'd5 || wb_wen !== 1'b1) begin failures++; $display("FAIL alu_reg act=%0d/%b exp=5/1", wb_reg, wb_wen); end
    checks++; if (dmemREN !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL alu_ren_stall2 act=%b%b exp=00", dmemREN, stall); end
    @(negedge CLK); idle();
    @(posedge CLK); #1;
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL alu_pulse act=%b exp=0", wb_valid); end
    checks++; if (wb_data !== 32'h10 || wb_reg !== 5'd5 || wb_wen !== 1'b1) begin failures++; $display("FAIL alu_hold act=%h/%0d/%b exp=10/5/1", wb_data, wb_reg, wb_wen); end
  endtask

  task automatic test_load();
    @(negedge CLK);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 32'h0, 5'd7);
    @(posedge CLK); #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      dhit = (k == 2); dmemload = (k == 2) ? 32'hDEADBEEF : $urandom;
      #1;
      checks++; if (dmemREN !== 1'b1 || dmemWEN !== 1'b0) begin failures++; $display("FAIL ld_ren c%0d act=%b%b exp=10", k, dmemREN, dmemWEN); end
      checks++; if (dmemaddr !== 32'h100) begin failures++; $display("FAIL ld_addr c%0d act=%h exp=100", k, dmemaddr); end
      checks++; if (stall !== (k != 2)) begin failures++; $display("FAIL ld_stall c%0d act=%b exp=%b", k, stall, (k != 2)); end
    end
    @(posedge CLK); #1;
    checks++; if (wb_valid !== 1'b1 || wb_data !== 32'hDEADBEEF) begin failures++; $display("FAIL ld_wb act=%b/%h exp=1/deadbeef", wb_valid, wb_data); end
    checks++; if (wb_reg !== 5'd7 || dmemREN !== 1'b0) begin failures++; $display("FAIL ld_reg_ren act=%0d/%b exp=7/0", wb_reg, dmemREN); end
    @(negedge CLK); idle(); dhit = 1'b0;
  endtask

  task automatic test_store();
    @(negedge CLK);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h200, 32'hCAFE0001, 32'h0, 32'h0, 5'd3);
    @(posedge CLK); #1;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      junk(1'b1); dhit = (k == 1);
      #1;
      checks++; if (dmemWEN !== 1'b1 || dmemREN !== 1'b0) begin failures++; $display("FAIL st_wen c%0d act=%b%b exp=10", k, dmemWEN, dmemREN); end
      checks++; if (dmemstore !== 32'hCAFE0001 || dmemaddr !== 32'h200) begin failures++; $display("FAIL st_data c%0d act=%h/%h exp=cafe0001/200", k, dmemstore, dmemaddr); end
    end
    @(posedge CLK); #1;
    checks++; if (wb_valid !== 1'b1 || wb_wen !== 1'b0) begin failures++; $display("FAIL st_wb act=%b/%b exp=1/0", wb_valid, wb_wen); end
    @(negedge CLK); idle(); dhit = 1'b0;
    // Read and write together behaves as a store
    @(negedge CLK);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h300, 32'h12345678, 32'h0, 32'h0, 5'd1);
    @(posedge CLK); #1;
    checks++; if (dmemWEN !== 1'b1 || dmemREN !== 1'b0) begin failures++; $display("FAIL rw_store act=%b%b exp=10", dmemWEN, dmemREN); end
    @(negedge CLK); idle(); dhit = 1'b1;
    @(posedge CLK); #1;
    checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL rw_wb act=%b exp=1", wb_valid); end
    @(negedge CLK); dhit = 1'b0;
  endtask

  task automatic test_back_to_back();
    @(negedge CLK);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 32'h0, 5'd9);
    @(posedge CLK); #1;
    @(negedge CLK);
    dhit = 1'b1; dmemload = 32'hA5A5_0001;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL b2b_stall act=%b exp=0", stall); end
    @(posedge CLK); #1;
    checks++; if (wb_valid !== 1'b1 || wb_data !== 32'hA5A5_0001 || wb_reg !== 5'd9) begin failures++; $display("FAIL b2b_first act=%b/%h/%0d exp=1/a5a50001/9", wb_valid, wb_data, wb_reg); end
    @(negedge CLK);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h77, 32'h0, 32'h1004, 32'h0, 5'd10);
    dhit = 1'b0;
    @(posedge CLK); #1;
    checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h1004 || wb_reg !== 5'd10) begin failures++; $display("FAIL b2b_second act=%b/%h/%0d exp=1/1004/10", wb_valid, wb_data, wb_reg); end
    @(negedge CLK); idle();
  endtask

  task automatic test_random();
    logic [31:0] a, s, p, lz, ld, exp;
    logic [4:0]  r;
    logic        rd, wr, m2r, rw, lu, jl;
    int          kind, lat;
    for (int n = 0; n < 40; n++) begin
      a = $urandom; s = $urandom; p = $urandom; lz = $urandom; ld = $urandom; r = 5'($urandom);
      kind = $urandom_range(0, 3);
      rd = (kind == 1 || kind == 3); wr = (kind == 2 || kind == 3);
      m2r = (kind == 1) ? 1'b1 : (kind == 0) ? 1'b0 : 1'($urandom);
      rw = 1'($urandom); lu = 1'($urandom); jl = 1'($urandom);
      exp = m2r ? ld : jl ? p : lu ? lz : a;
      @(negedge CLK);
      drive(1'b1, rd, wr, m2r, rw, lu, jl, 1'b0, a, s, p, lz, r);
      dhit = 1'b0; dmemload = ld;
      if (rd || wr) begin
        @(posedge CLK); #1;
        lat = $urandom_range(0, 3);
        for (int k = 0; k <= lat; k++) begin
          @(negedge CLK);
          junk(1'($urandom));
          dhit = (k == lat); dmemload = (k == lat) ? ld : $urandom;
          #1;
          checks++; if (dmemREN !== (rd && !wr) || dmemWEN !== wr) begin failures++; $display("FAIL rnd_req n%0d act=%b%b exp=%b%b", n, dmemREN, dmemWEN, rd && !wr, wr); end
          checks++; if (dmemaddr !== a || dmemstore !== s) begin failures++; $display("FAIL rnd_addr n%0d act=%h/%h exp=%h/%h", n, dmemaddr, dmemstore, a, s); end
          checks++; if (stall !== (k != lat)) begin failures++; $display("FAIL rnd_stall n%0d act=%b exp=%b", n, stall, (k != lat)); end
        end
      end
      @(posedge CLK); #1;
      checks++; if (wb_valid !== 1'b1 || wb_data !== exp) begin failures++; $display("FAIL rnd_wb n%0d act=%b/%h exp=1/%h", n, wb_valid, wb_data, exp); end
      checks++; if (wb_reg !== r || wb_wen !== rw) begin failures++; $display("FAIL rnd_reg n%0d act=%0d/%b exp=%0d/%b", n, wb_reg, wb_wen, r, rw); end
      @(negedge CLK);
      junk(1'b0); dhit = 1'($urandom);
      @(posedge CLK); #1;
      checks++; if (wb_valid !== 1'b0 || wb_data !== exp || stall !== 1'b0) begin failures++; $display("FAIL rnd_idle n%0d act=%b/%h/%b exp=0/%h/0", n, wb_valid, wb_data, stall, exp); end
    end
    @(negedge CLK); idle(); dhit = 1'b0;
  endtask

  task automatic test_reset_in_access();
    @(negedge CLK);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h500, 32'h0, 32'h0, 32'h0, 5'd4);
    @(posedge CLK); #1;
    checks++; if (dmemREN !== 1'b1) begin failures++; $display("FAIL rsta_pre act=%b exp=1", dmemREN); end
    #2;
    nRST = 1'b0; dhit = 1'b1; dmemload = 32'h1111_2222;
    #1;
    checks++; if (dmemREN !== 1'b0 || wb_valid !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL rsta_async act=%b%b%b exp=000", dmemREN, wb_valid, stall); end
    @(posedge CLK); #1;
    @(negedge CLK);
    nRST = 1'b1; idle(); dhit = 1'b0;
    @(posedge CLK); #1;
    checks++; if (wb_valid !== 1'b0 || wb_data !== 32'h0 || dmemREN !== 1'b0) begin failures++; $display("FAIL rsta_after act=%b/%h/%b exp=0/0/0", wb_valid, wb_data, dmemREN); end
  endtask

`ifdef MEM_STAGE_PERF_CNT_EN
  task automatic test_perf_cnt();
    reset_dut();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h80, 32'h0, 32'h0, 32'h0, 5'd2);
    @(posedge CLK); #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK); idle(); dhit = (k == 2);
    end
    @(posedge CLK); #1;
    @(negedge CLK); dhit = 1'b0;
    checks++; if (access_cnt !== 32'd1 || stall_cnt !== 32'd2) begin failures++; $display("FAIL perf_cnt act=%0d/%0d exp=1/2", access_cnt, stall_cnt); end
  endtask
`endif

  task automatic test_halt();
`ifdef MEM_STAGE_PERF_CNT_EN
    logic [31:0] acc0;
    acc0 = access_cnt;
`endif
    @(negedge CLK);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 5'd6);
    @(posedge CLK); #1;
    checks++; if (halt_out !== 1'b1 || wb_valid !== 1'b1 || wb_wen !== 1'b0) begin failures++; $display("FAIL halt_enter act=%b/%b/%b exp=1/1/0", halt_out, wb_valid, wb_wen); end
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 32'h0, 5'd8);
      dhit = 1'($urandom);
      #1;
      checks++; if (dmemREN !== 1'b0 || dmemWEN !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL halt_req k%0d act=%b%b%b exp=000", k, dmemREN, dmemWEN, stall); end
      @(posedge CLK); #1;
      checks++; if (halt_out !== 1'b1 || wb_valid !== 1'b0) begin failures++; $display("FAIL halt_sticky k%0d act=%b/%b exp=1/0", k, halt_out, wb_valid); end
    end
`ifdef MEM_STAGE_PERF_CNT_EN
    checks++; if (access_cnt !== acc0) begin failures++; $display("FAIL halt_acc act=%0d exp=%0d", access_cnt, acc0); end
`endif
    @(negedge CLK); idle(); dhit = 1'b0;
  endtask

  initial begin
    idle(); dhit = 1'b0; dmemload = 32'h0;
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_back_to_back();
    test_random();
    test_reset_in_access();
`ifdef MEM_STAGE_PERF_CNT_EN
    test_perf_cnt();
`endif
    test_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
